// File: rtl/npc_pkg.sv
// Shared next-pc definitions: control-flow kind encodings and the
// redirect block's pending-state encoding {out_pend, redir_pend}.
package npc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_BRANCH = 2'b01,
        KIND_JAL    = 2'b10,
        KIND_JALR   = 2'b11
    } kind_e;

    // Bit 1 = writeback pending, bit 0 = fetch redirect pending.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_REDIR = 2'b01,
        ST_OUT   = 2'b10,
        ST_BOTH  = 2'b11
    } state_e;

endpackage

// File: rtl/bru_target.sv
// Combinational branch target, take decision and misalignment check.
module bru_target
    import npc_pkg::*;
(
    input  logic [1:0]      kind,
    input  logic            taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            take,
    output logic            misalign
);

    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] rs1_sum;

    assign pc_sum  = pc + imm;
    assign rs1_sum = rs1 + imm;

    // jalr clears bit 0 of its target; everything else is pc-relative.
    always_comb begin
        target   = pc_sum;
        take     = 1'b0;
        case (kind_e'(kind))
            KIND_NONE:   take = 1'b0;
            KIND_BRANCH: take = taken;
            KIND_JAL:    take = 1'b1;
            KIND_JALR: begin
                take   = 1'b1;
                target = {rs1_sum[XLEN-1:1], 1'b0};
            end
            default:     take = 1'b0;
        endcase
        misalign = take & target[1];
    end

endmodule

// File: rtl/branch_redirect.sv
// Resolved control-flow op holding stage: registers one op, then presents
// it on a writeback handshake and, when taken and aligned, on a fetch
// redirect handshake. A new op is only accepted once the redirect drained.
module branch_redirect
    import npc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      in_kind_i,
    input  logic            in_taken_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic [XLEN-1:0] in_rs1_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_link_o,
    output logic            out_misalign_o,
    output logic            redir_valid_o,
    input  logic            redir_ready_i,
    output logic [XLEN-1:0] redir_pc_o,
    output logic            flush_o,
    output logic [XLEN-1:0] redir_cnt_o
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] target;
    logic            take;
    logic            misalign;
    logic            accept;
    logic            redir_fire;
    logic            redir_new;

    logic [XLEN-1:0] pc_q, link_q, rpc_q, cnt_q;
    logic            mis_q;

    bru_target u_bru_target (
        .kind     (in_kind_i),
        .taken    (in_taken_i),
        .pc       (in_pc_i),
        .imm      (in_imm_i),
        .rs1      (in_rs1_i),
        .target   (target),
        .take     (take),
        .misalign (misalign)
    );

    assign accept     = in_valid_i & in_ready_o;
    assign redir_fire = redir_valid_o & redir_ready_i;
    // Misaligned targets are reported on writeback instead of redirecting.
    assign redir_new  = take & ~misalign;

    // State register; reset drops any pending op without firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state from accept and the two independent drain handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = redir_new ? ST_BOTH : ST_OUT;
            ST_OUT: begin
                if (accept)           state_d = redir_new ? ST_BOTH : ST_OUT;
                else if (out_ready_i) state_d = ST_EMPTY;
            end
            ST_REDIR: if (redir_ready_i) state_d = ST_EMPTY;
            ST_BOTH: begin
                case ({out_ready_i, redir_ready_i})
                    2'b11:   state_d = ST_EMPTY;
                    2'b10:   state_d = ST_REDIR;
                    2'b01:   state_d = ST_OUT;
                    default: state_d = ST_BOTH;
                endcase
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from state; accept overlaps an out fire.
    always_comb begin
        out_valid_o   = state_q[1];
        redir_valid_o = state_q[0];
        in_ready_o    = (state_q == ST_EMPTY) | ((state_q == ST_OUT) & out_ready_i);
        flush_o       = state_q[0] & redir_ready_i;
    end

    // Held op fields only change on accept, so they are stable until fired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            link_q <= '0;
            rpc_q  <= '0;
            mis_q  <= 1'b0;
        end else if (accept) begin
            pc_q   <= in_pc_i;
            link_q <= in_pc_i + 32'd4;
            rpc_q  <= target;
            mis_q  <= misalign;
        end
    end

    // Completed-redirect counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt_q <= '0;
        else if (redir_fire) cnt_q <= cnt_q + 32'd1;
    end

    assign out_pc_o       = pc_q;
    assign out_link_o     = link_q;
    assign redir_pc_o     = rpc_q;
    assign out_misalign_o = mis_q;
    assign redir_cnt_o    = cnt_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: directed scenarios plus random traffic, all
// checked against a transaction-level model of the op holding stage.
module tb_branch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  in_kind_i;
    logic        in_taken_i;
    logic [31:0] in_pc_i, in_imm_i, in_rs1_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_pc_o, out_link_o;
    logic        out_misalign_o;
    logic        redir_valid_o, redir_ready_i;
    logic [31:0] redir_pc_o;
    logic        flush_o;
    logic [31:0] redir_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the held op: pending flags plus captured fields.
    bit          m_out, m_redir, m_mis;
    logic [31:0] m_pc, m_link, m_rpc, m_cnt;

    always #5 clk = ~clk;

    branch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_kind_i      (in_kind_i),
        .in_taken_i     (in_taken_i),
        .in_pc_i        (in_pc_i),
        .in_imm_i       (in_imm_i),
        .in_rs1_i       (in_rs1_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_pc_o       (out_pc_o),
        .out_link_o     (out_link_o),
        .out_misalign_o (out_misalign_o),
        .redir_valid_o  (redir_valid_o),
        .redir_ready_i  (redir_ready_i),
        .redir_pc_o     (redir_pc_o),
        .flush_o        (flush_o),
        .redir_cnt_o    (redir_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_redir = 0; m_mis = 0;
        m_pc = 0; m_link = 0; m_rpc = 0; m_cnt = 0;
    endtask

    // One cycle: drive at negedge, check outputs, advance model to next edge.
    task automatic step(input bit v, input logic [1:0] k, input bit t,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input bit ordy, input bit rrdy);
        bit          exp_ready, acc, tk;
        logic [31:0] tgt;
        @(negedge clk);
        in_valid_i = v; in_kind_i = k; in_taken_i = t;
        in_pc_i = pc; in_imm_i = imm; in_rs1_i = rs1;
        out_ready_i = ordy; redir_ready_i = rrdy;
        #1;
        exp_ready = !m_redir && (!m_out || ordy);
        chk("in_ready",    {31'd0, in_ready_o},     {31'd0, exp_ready});
        chk("out_valid",   {31'd0, out_valid_o},    {31'd0, m_out});
        chk("redir_valid", {31'd0, redir_valid_o},  {31'd0, m_redir});
        chk("flush",       {31'd0, flush_o},        {31'd0, m_redir && rrdy});
        chk("misalign",    {31'd0, out_misalign_o}, {31'd0, m_mis});
        chk("out_pc",      out_pc_o,   m_pc);
        chk("out_link",    out_link_o, m_link);
        chk("redir_pc",    redir_pc_o, m_rpc);
        chk("redir_cnt",   redir_cnt_o, m_cnt);
        acc = v && exp_ready;
        if (m_out && ordy) m_out = 0;
        if (m_redir && rrdy) begin m_redir = 0; m_cnt = m_cnt + 1; end
        if (acc) begin
            tgt = (k == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
            tk  = (k == 2'b01 && t) || k == 2'b10 || k == 2'b11;
            m_pc = pc; m_link = pc + 4; m_rpc = tgt;
            m_mis = tk && tgt[1];
            m_out = 1;
            m_redir = tk && !tgt[1];
        end
    endtask

    task automatic idle(input bit ordy, input bit rrdy);
        step(0, 2'b00, 0, 0, 0, 0, ordy, rrdy);
    endtask

    initial begin
        rst = 1; in_valid_i = 0; in_kind_i = 0; in_taken_i = 0;
        in_pc_i = 0; in_imm_i = 0; in_rs1_i = 0; out_ready_i = 0; redir_ready_i = 0;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_redir_valid", {31'd0, redir_valid_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_cnt", redir_cnt_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        idle(1, 1);

        // Taken branch, both readies high.
        step(1, 2'b01, 1, 32'h8000_0000, 32'h10, 0, 1, 1);
        idle(1, 1);
        chk("b_redir_pc", redir_pc_o, 32'h8000_0010);
        chk("b_flush", {31'd0, flush_o}, 32'd1);
        chk("b_link", out_link_o, 32'h8000_0004);
        idle(1, 1);
        chk("b_cnt", redir_cnt_o, 32'd1);

        // Misaligned jalr target: reported, never redirected.
        step(1, 2'b11, 0, 32'h100, 32'h0, 32'h8000_1003, 1, 1);
        idle(1, 1);
        chk("j_redir_pc", redir_pc_o, 32'h8000_1002);
        chk("j_misalign", {31'd0, out_misalign_o}, 32'd1);
        chk("j_no_redir", {31'd0, redir_valid_o}, 32'd0);
        idle(1, 1);
        chk("j_cnt", redir_cnt_o, 32'd1);

        // Back-to-back not-taken branches stream with no bubble.
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b01, 0, 32'h2000 + 32'(i * 4), 32'h40, 0, 1, 1);
            chk("nt_ready", {31'd0, in_ready_o}, 32'd1);
        end
        idle(1, 1);

        // jal with fetch stalled 4 cycles: op offered but blocked.
        step(1, 2'b10, 0, 32'h3000, 32'h100, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b01, 0, 32'h4000, 32'h8, 0, 1, 0);
            chk("stall_ready", {31'd0, in_ready_o}, 32'd0);
        end
        step(0, 2'b00, 0, 0, 0, 0, 1, 1);
        chk("stall_flush", {31'd0, flush_o}, 32'd1);
        idle(1, 1);
        chk("stall_flush_gone", {31'd0, flush_o}, 32'd0);

        // Reset while both handshakes pending.
        step(1, 2'b10, 0, 32'h5000, 32'h20, 0, 0, 0);
        idle(0, 0);
        chk("both_pending", {30'd0, out_valid_o, redir_valid_o}, 32'd3);
        @(negedge clk);
        redir_ready_i = 1; out_ready_i = 1; rst = 1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_redir_valid", {31'd0, redir_valid_o}, 32'd0);
        chk("mid_rst_flush", {31'd0, flush_o}, 32'd0);
        chk("mid_rst_cnt", redir_cnt_o, 32'd0);
        chk("mid_rst_pc", out_pc_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        idle(1, 1);

        // Counter wrap: preload near the top, then two redirects.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            step(1, 2'b10, 0, 32'h6000, 32'h40, 0, 1, 1);
            idle(1, 1);
        end
        idle(1, 1);
        chk("cnt_wrap", redir_cnt_o, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) - 32'd32 : $urandom;
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, imm, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
BRANCH_REDIRECT -- requirements
Module: branch_redirect

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in_valid_i  input  1  resolved control-flow op offered.
REQ-004 SHALL have port: in_ready_o  output  1  block accepts op this cycle.
REQ-005 SHALL have port: in_kind_i  input  2  00 none, 01 branch, 10 jal, 11 jalr.
REQ-006 SHALL have port: in_taken_i  input  1  branch comparator result; ignored unless kind=01.
REQ-007 SHALL have port: in_pc_i, in_imm_i, in_rs1_i  input  32 each  pc, sign-extended immediate, rs1 value.
REQ-008 SHALL have port: out_valid_o / out_ready_i  output / input  1 / 1  writeback handshake.
REQ-009 SHALL have port: out_pc_o, out_link_o  output  32 each  held pc, pc+4.
REQ-010 SHALL have port: out_misalign_o  output  1  taken target not 4-byte aligned.
REQ-011 SHALL have port: redir_valid_o / redir_ready_i  output / input  1 / 1  fetch redirect handshake.
REQ-012 SHALL have port: redir_pc_o  output  32  redirect target.
REQ-013 SHALL have port: flush_o  output  1  one-cycle pulse on redirect fire.
REQ-014 SHALL have port: redir_cnt_o  output  32  count of completed redirects.

Function
REQ-015 Accept (in fire) SHALL occur when in_valid_i & in_ready_o; operands registered; one-cycle latency to out_valid_o / redir_valid_o.
REQ-016 Target SHALL be pc+imm for kind 01/10; (rs1+imm) & ~1 for kind 11; 32-bit, modulo 2^32.
REQ-017 take = (kind=01 & taken) | kind=10 | kind=11; kind=00 never takes.
REQ-018 If take & target[1]=1: out_misalign_o=1, no redirect; else if take: redirect pending.
REQ-019 Every accepted op SHALL set out pending; state = {out_pend, redir_pend}: EMPTY 00, OUT 10, REDIR 01, BOTH 11.
REQ-020 out_valid_o = out_pend; redir_valid_o = redir_pend; out fire clears out_pend; redir fire clears redir_pend.
REQ-021 Transitions: EMPTY->OUT or BOTH on accept; BOTH->REDIR on out fire, BOTH->OUT on redir fire, BOTH->EMPTY on both same cycle; OUT->EMPTY, REDIR->EMPTY on respective fire.
REQ-022 in_ready_o = (state EMPTY) | (state OUT & out_ready_i); 0 whenever redir_pend=1.
REQ-023 Accept in same cycle as out fire (OUT state) SHALL load new op with no bubble.
REQ-024 flush_o = redir_valid_o & redir_ready_i, combinational, exactly one cycle per redirect.
REQ-025 redir_cnt_o SHALL increment by 1 per redir fire, wrapping 0xFFFFFFFF->0.
REQ-026 Held outputs (pc, link, redir_pc, misalign) SHALL stay stable while their valid is high and not fired.

Reset
REQ-027 rst high SHALL immediately force state EMPTY, redir_cnt_o=0, all held registers 0.
REQ-028 During/after reset: in_ready_o=1 (after release), out_valid_o=0, redir_valid_o=0, flush_o=0, out_misalign_o=0.
REQ-029 Reset mid-handshake SHALL drop pending op without flush_o pulse or count increment.

Structure
REQ-030 Kind encodings and state encoding SHALL live in the shared npc package.
REQ-031 Target/misalign computation SHALL be sub-module bru_target (combinational); rest in branch_redirect.

Verification
REQ-032 branch pc=0x80000000 imm=0x10 taken=1, both readies 1 -> next cycle redir_pc_o=0x80000010, flush_o=1, out_link_o=0x80000004, cnt=1.
REQ-033 jalr rs1=0x80001003 imm=0 -> redir_pc_o=0x80001002, out_misalign_o=1, no redirect, cnt unchanged.
REQ-034 branch taken=0, out_ready_i=1 held, 3 back-to-back ops -> in_ready_o=1 every cycle, 3 out fires, no redirect.
REQ-035 jal, redir_ready_i low 4 cycles, out_ready_i=1 -> state REDIR, in_ready_o=0 all 4 cycles, single flush_o on 5th.
REQ-036 rst asserted in BOTH state -> outputs zero same cycle, no flush_o, cnt=0.
REQ-037 preload cnt to 0xFFFFFFFF via repeated redirects (or force) then one redirect -> cnt=0.
